// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_arbiter
// Description : Round-robin arbiter sharing one 8-operation ALU among NREQ
//               valid/ready requesters. Define ALU_ARB_PRIO0_EN to give
//               requester 0 fixed top priority over the round-robin group.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic [3:0]            rsp_flags
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_EXEC = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam int         c_MSB  = WIDTH - 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_gnt;
    logic [IDW-1:0]   w_gnt_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [WIDTH-1:0] r_rsp_result;
    logic [3:0]       r_rsp_flags;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    int               w_idx;
    logic             w_hs;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;

    // Scan upward from ptr with wrap; with the priority option requester 0
    // pre-empts the scan whenever it is valid.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
`ifdef ALU_ARB_PRIO0_EN
        if (req_valid[0]) begin
            w_found = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = IDW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_found) w_state_nxt = c_EXEC;
            c_EXEC:  w_state_nxt = c_RESP;
            c_RESP:  if (rsp_ready) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // rst_n gating keeps req_ready low while reset is held with requests pending.
    always_comb begin
        req_ready = '0;
        w_hs      = (r_state == c_IDLE) && w_found;
        if (w_hs && rst_n) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = {1'b0, r_a} - {1'b0, r_b};
        w_res  = '0;
        w_c    = 1'b0;
        w_v    = 1'b0;
        case (r_op)
            3'b000: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[c_MSB] == r_b[c_MSB]) && (w_sum[c_MSB] != r_a[c_MSB]);
            end
            3'b001: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = ~w_diff[WIDTH];
                w_v   = (r_a[c_MSB] != r_b[c_MSB]) && (w_diff[c_MSB] != r_a[c_MSB]);
            end
            3'b010: w_res = r_a & r_b;
            3'b011: w_res = r_a | r_b;
            3'b100: w_res = r_a ^ r_b;
            3'b101: w_res = ~r_a;
            3'b110: begin
                w_res = {r_a[WIDTH-2:0], 1'b0};
                w_c   = r_a[c_MSB];
            end
            3'b111: begin
                w_res = {1'b0, r_a[WIDTH-1:1]};
                w_c   = r_a[0];
            end
        endcase
    end

    assign w_gnt_nxt = (r_gnt == IDW'(NREQ - 1)) ? '0 : r_gnt + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_gnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_gnt <= w_win;
                        r_a   <= req_a[w_win*WIDTH +: WIDTH];
                        r_b   <= req_b[w_win*WIDTH +: WIDTH];
                        r_op  <= req_op[w_win*3 +: 3];
                    end
                end
                c_EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_id     <= r_gnt;
                    r_rsp_result <= w_res;
                    r_rsp_flags  <= {w_c, (w_res == '0), w_v, w_res[c_MSB]};
`ifdef ALU_ARB_PRIO0_EN
                    if (r_gnt != '0) begin
                        r_ptr <= w_gnt_nxt;
                    end
`else
                    r_ptr <= w_gnt_nxt;
`endif
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_rsp_valid <= 1'b0;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;

endmodule
`default_nettype wire
